// File: rtl/clock_divider_pkg.sv
// Shared board-timing constants for the ultrasonic front end.
// Holds the default timebase divisor and the legal divisor range.
package clock_divider_pkg;

    localparam int unsigned BOARD_CLK_HZ    = 50_000_000;
    localparam int unsigned DEFAULT_DIVISOR = 50;          // 50 MHz / 50 = 1 us timebase
    localparam int unsigned MIN_DIVISOR     = 2;
    localparam int unsigned MAX_DIVISOR     = 65535;

endpackage

// File: rtl/clock_divider.sv
// Integer clock divider producing a registered square wave (ClockOut) and a
// one-cycle Tick strobe per period, both synchronous to ClockIn.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int unsigned DIVISOR = DEFAULT_DIVISOR
) (
    input  logic ClockIn,
    input  logic Reset,
    input  logic Enable,
    output logic ClockOut,
    output logic Tick
);

    localparam int unsigned HIGH_CYCLES = DIVISOR / 2;
    localparam int unsigned CW          = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST      = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HIGH      = CW'(HIGH_CYCLES);

    generate
        if (DIVISOR < MIN_DIVISOR || DIVISOR > MAX_DIVISOR) begin : g_bad_divisor
            $error("clock_divider: DIVISOR %0d outside legal range 2..65535", DIVISOR);
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;

    // Output decisions use the pre-edge count; a frozen divider holds phase and drops Tick.
    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (Enable) begin
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            clk_d  = (cnt_q < HIGH);
            tick_d = (cnt_q == LAST);
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign ClockOut = clk_q;
    assign Tick     = tick_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider at DIVISOR = 50, 5 and 2.
module tb_clock_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst50 = 1'b1, en50 = 1'b0, co50, tk50;
    logic rst5  = 1'b1, en5  = 1'b0, co5,  tk5;
    logic rst2  = 1'b1, en2  = 1'b0, co2,  tk2;

    clock_divider #(.DIVISOR(50)) u_d50 (
        .ClockIn(clk), .Reset(rst50), .Enable(en50), .ClockOut(co50), .Tick(tk50));
    clock_divider #(.DIVISOR(5)) u_d5 (
        .ClockIn(clk), .Reset(rst5), .Enable(en5), .ClockOut(co5), .Tick(tk5));
    clock_divider #(.DIVISOR(2)) u_d2 (
        .ClockIn(clk), .Reset(rst2), .Enable(en2), .ClockOut(co2), .Tick(tk2));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   dut;
        logic rst;
        logic en;
        logic co;
        logic tk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int dut, input logic rst, input logic en,
                                input logic co, input logic tk);
        vec_t v;
        v.dut = dut; v.rst = rst; v.en = en; v.co = co; v.tk = tk;
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Enabled-edge index since last reset release for the DIVISOR=50 instance.
    int k = 0;
    int last_tick_k = 0;
    int hi_run = 0;

    task automatic run50(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            rst50 = 1'b0;
            en50  = 1'b1;
            step();
            k++;
            chk({tag, "_co"}, co50, (((k - 1) % 50) < 25));
            chk({tag, "_tick"}, tk50, ((k % 50) == 0));
            if (tk50 === 1'b1) begin
                if (last_tick_k > 0) chk_int({tag, "_tick_period"}, k - last_tick_k, 50);
                last_tick_k = k;
            end
            if (co50 === 1'b1) begin
                hi_run++;
            end else if (hi_run > 0) begin
                chk_int({tag, "_high_len"}, hi_run, 25);
                hi_run = 0;
            end
        end
    endtask

    task automatic restart50();
        k = 0;
        last_tick_k = 0;
        hi_run = 0;
    endtask

    initial begin
        // DIVISOR=5: reset, 1,1,0,0,0 pattern, pause mid-period, reset with enable.
        vecs.push_back(mk(5, 1, 0, 0, 0));
        vecs.push_back(mk(5, 1, 0, 0, 0));
        vecs.push_back(mk(5, 0, 1, 1, 0));
        vecs.push_back(mk(5, 0, 1, 1, 0));
        vecs.push_back(mk(5, 0, 1, 0, 0));
        vecs.push_back(mk(5, 0, 1, 0, 0));
        vecs.push_back(mk(5, 0, 1, 0, 1));
        vecs.push_back(mk(5, 0, 1, 1, 0));
        vecs.push_back(mk(5, 0, 1, 1, 0));
        vecs.push_back(mk(5, 0, 0, 1, 0));
        vecs.push_back(mk(5, 0, 0, 1, 0));
        vecs.push_back(mk(5, 0, 1, 0, 0));
        vecs.push_back(mk(5, 0, 1, 0, 0));
        vecs.push_back(mk(5, 0, 1, 0, 1));
        vecs.push_back(mk(5, 0, 1, 1, 0));
        vecs.push_back(mk(5, 1, 1, 0, 0));
        vecs.push_back(mk(5, 0, 1, 1, 0));
        vecs.push_back(mk(5, 0, 1, 1, 0));
        vecs.push_back(mk(5, 0, 1, 0, 0));
        // DIVISOR=2: 1,0,1,0 with Tick 0,1,0,1; pause holds low; resume.
        vecs.push_back(mk(2, 1, 0, 0, 0));
        vecs.push_back(mk(2, 0, 1, 1, 0));
        vecs.push_back(mk(2, 0, 1, 0, 1));
        vecs.push_back(mk(2, 0, 1, 1, 0));
        vecs.push_back(mk(2, 0, 1, 0, 1));
        vecs.push_back(mk(2, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 1, 1, 0));
        vecs.push_back(mk(2, 0, 1, 0, 1));
        vecs.push_back(mk(2, 1, 1, 0, 0));
        vecs.push_back(mk(2, 0, 1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].dut == 5) begin
                rst5 = vecs[i].rst;
                en5  = vecs[i].en;
            end else begin
                rst2 = vecs[i].rst;
                en2  = vecs[i].en;
            end
            step();
            if (vecs[i].dut == 5) begin
                chk($sformatf("d5_vec%0d_co", i), co5, vecs[i].co);
                chk($sformatf("d5_vec%0d_tick", i), tk5, vecs[i].tk);
            end else begin
                chk($sformatf("d2_vec%0d_co", i), co2, vecs[i].co);
                chk($sformatf("d2_vec%0d_tick", i), tk2, vecs[i].tk);
            end
        end

        // DIVISOR=50: reset for 3 cycles, then 200 enabled edges.
        rst50 = 1'b1;
        en50  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("d50_reset_co", co50, 1'b0);
            chk("d50_reset_tick", tk50, 1'b0);
        end
        restart50();
        run50(200, "d50_run");

        // Freeze at cnt=10 for 17 cycles; next Tick 40 enabled edges after resume.
        run50(10, "d50_pre_pause");
        en50 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            chk("d50_pause_co", co50, 1'b1);
            chk("d50_pause_tick", tk50, 1'b0);
        end
        run50(39, "d50_resume");
        chk("d50_resume_no_early_tick", tk50, 1'b0);
        run50(1, "d50_resume_last");
        chk("d50_resume_tick_at_40", tk50, 1'b1);

        // Reset mid-period at cnt=30 (ClockOut low), then a fresh sequence.
        run50(30, "d50_to_cnt30");
        chk("d50_cnt30_co_low", co50, 1'b0);
        rst50 = 1'b1;
        en50  = 1'b1;
        step();
        chk("d50_midreset_co", co50, 1'b0);
        chk("d50_midreset_tick", tk50, 1'b0);
        restart50();
        run50(60, "d50_after_reset");

        // Reset and Enable together: reset wins.
        rst50 = 1'b1;
        en50  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("d50_rst_prio_co", co50, 1'b0);
            chk("d50_rst_prio_tick", tk50, 1'b0);
        end
        restart50();
        run50(51, "d50_after_prio");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
